// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-bus signals of the memory access unit.
// The master modport is the unit itself; the slave modport is the pipeline/bus environment.
interface mem_access_unit_if;
    logic        valid_in;
    logic        write_mem;
    logic        mem_to_regfile;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dest_reg;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall;
    logic        load_valid;
    logic        load_we;
    logic [4:0]  load_reg;
    logic [31:0] load_data;
    logic        addr_err;
    logic        addr_err_st;
    logic [31:0] badvaddr;

    modport master (
        input  valid_in, write_mem, mem_to_regfile, addr, wdata, dest_reg,
        input  data_addr_ok, data_data_ok, data_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        output stall, load_valid, load_we, load_reg, load_data,
        output addr_err, addr_err_st, badvaddr
    );

    modport slave (
        output valid_in, write_mem, mem_to_regfile, addr, wdata, dest_reg,
        output data_addr_ok, data_data_ok, data_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        input  stall, load_valid, load_we, load_reg, load_data,
        input  addr_err, addr_err_st, badvaddr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one word access on the data bus per
// lw/sw, stalls the pipeline while it is outstanding and flags misaligned addresses.
module mem_access_unit (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        data_req_q, data_req_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        load_valid_q, load_valid_d;
    logic        load_we_q, load_we_d;
    logic [4:0]  load_reg_q, load_reg_d;
    logic [31:0] load_data_q, load_data_d;
    logic        addr_err_q, addr_err_d;
    logic        addr_err_st_q, addr_err_st_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic mem_op, aligned, accept, fault, finish;

    assign mem_op  = bus.valid_in & (bus.write_mem | bus.mem_to_regfile);
    assign aligned = (bus.addr[1:0] == 2'b00);
    assign accept  = (state_q == IDLE) & mem_op & aligned;
    assign fault   = (state_q == IDLE) & mem_op & ~aligned;
    // Completion: data_ok together with addr_ok in REQ, or data_ok alone in WAIT.
    assign finish  = ((state_q == REQ) & bus.data_addr_ok & bus.data_data_ok) |
                     ((state_q == WAIT) & bus.data_data_ok);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (bus.data_addr_ok) state_d = bus.data_data_ok ? DONE : WAIT;
            end
            WAIT: if (bus.data_data_ok) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_req_d    = data_req_q;
        data_wr_d     = data_wr_q;
        data_addr_d   = data_addr_q;
        data_wdata_d  = data_wdata_q;
        load_reg_d    = load_reg_q;
        load_data_d   = load_data_q;
        addr_err_st_d = addr_err_st_q;
        badvaddr_d    = badvaddr_q;
        load_valid_d  = 1'b0;
        load_we_d     = 1'b0;
        addr_err_d    = 1'b0;

        if (accept) begin
            data_req_d   = 1'b1;
            data_wr_d    = bus.write_mem;
            data_addr_d  = bus.addr;
            data_wdata_d = bus.wdata;
            load_reg_d   = bus.dest_reg;
        end else if (fault) begin
            addr_err_d    = 1'b1;
            addr_err_st_d = bus.write_mem;
            badvaddr_d    = bus.addr;
        end

        if ((state_q == REQ) && bus.data_addr_ok) data_req_d = 1'b0;

        if (finish) begin
            if (!data_wr_q) load_data_d = bus.data_rdata;
            load_valid_d = 1'b1;
            load_we_d    = ~data_wr_q & (load_reg_q != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_req_q    <= 1'b0;
            data_wr_q     <= 1'b0;
            data_addr_q   <= '0;
            data_wdata_q  <= '0;
            load_valid_q  <= 1'b0;
            load_we_q     <= 1'b0;
            load_reg_q    <= '0;
            load_data_q   <= '0;
            addr_err_q    <= 1'b0;
            addr_err_st_q <= 1'b0;
            badvaddr_q    <= '0;
        end else begin
            data_req_q    <= data_req_d;
            data_wr_q     <= data_wr_d;
            data_addr_q   <= data_addr_d;
            data_wdata_q  <= data_wdata_d;
            load_valid_q  <= load_valid_d;
            load_we_q     <= load_we_d;
            load_reg_q    <= load_reg_d;
            load_data_q   <= load_data_d;
            addr_err_q    <= addr_err_d;
            addr_err_st_q <= addr_err_st_d;
            badvaddr_q    <= badvaddr_d;
        end
    end

    assign bus.data_req    = data_req_q;
    assign bus.data_wr     = data_wr_q;
    assign bus.data_size   = 2'b10;
    assign bus.data_addr   = data_addr_q;
    assign bus.data_wdata  = data_wdata_q;
    assign bus.load_valid  = load_valid_q;
    assign bus.load_we     = load_we_q;
    assign bus.load_reg    = load_reg_q;
    assign bus.load_data   = load_data_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.addr_err_st = addr_err_st_q;
    assign bus.badvaddr    = badvaddr_q;
    assign bus.stall       = ~reset & (accept | (state_q == REQ) | (state_q == WAIT));
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock `clk`, reset `reset`; all state updates on the rising edge of `clk`.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  instruction in the memory stage is valid
- write_mem  in  1  store request (sw) from decode control
- mem_to_regfile  in  1  load request (lw) from decode control
- addr  in  32  effective address from ALU
- wdata  in  32  store data (forwarded rt)
- dest_reg  in  5  load destination register
- data_req  out  1  bus request
- data_wr  out  1  1 = write, 0 = read
- data_size  out  2  fixed 2'b10 (word)
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted by bus
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  bus read data
- stall  out  1  hold upstream pipeline
- load_valid  out  1  one-cycle writeback strobe
- load_we  out  1  regfile write enable for this load
- load_reg  out  5  writeback register
- load_data  out  32  loaded word
- addr_err  out  1  one-cycle misaligned-access pulse
- addr_err_st  out  1  1 = store fault (AdES), 0 = load fault (AdEL)
- badvaddr  out  32  faulting address

Function
REQ-003 The block SHALL implement an FSM with states IDLE, REQ, WAIT, DONE.
REQ-004 In IDLE, when valid_in & (write_mem | mem_to_regfile) and addr[1:0] == 2'b00, the block SHALL perform an accept: latch addr, wdata, dest_reg and the write flag (write_mem), then go to REQ.
REQ-005 If write_mem and mem_to_regfile are both high, the access SHALL be treated as a store.
REQ-006 In IDLE, on a valid access with addr[1:0] != 0, the block SHALL:
- issue no bus request;
- register addr_err = 1 for exactly one cycle, with addr_err_st = the write flag and badvaddr = addr;
- remain in IDLE.
REQ-007 In REQ, the block SHALL hold data_req = 1 with data_addr, data_wr and data_wdata driven from the latched values and stable until data_addr_ok is sampled high.
REQ-008 In REQ, on data_addr_ok & !data_data_ok, the FSM SHALL go to WAIT.
REQ-009 In REQ, on data_addr_ok & data_data_ok in the same cycle, the FSM SHALL go directly to DONE and capture data_rdata.
REQ-010 In WAIT, data_req SHALL be 0; on data_data_ok, the block SHALL capture data_rdata into load_data and go to DONE.
REQ-011 DONE SHALL last exactly one cycle and then return to IDLE. During DONE:
- load_valid = 1;
- load_reg = latched dest_reg;
- load_we = 1 only for a load with dest_reg != 0.
REQ-012 For stores, DONE SHALL still assert load_valid = 1 with load_we = 0.
REQ-013 stall SHALL be combinationally 1 in the accept cycle (REQ-004) and throughout REQ and WAIT, and 0 in DONE and in idle non-accept cycles.
REQ-014 valid_in, write_mem and mem_to_regfile SHALL be ignored outside IDLE.
REQ-015 data_data_ok or data_addr_ok arriving in IDLE or DONE SHALL be ignored with no output change.
REQ-016 Minimum latency SHALL be: accept at cycle T, data_req at T+1, load_valid at T+2 when data_addr_ok & data_data_ok are both high at T+1. Each bus wait cycle adds one cycle.
REQ-017 data_size SHALL be constant 2'b10; data_addr SHALL equal the latched addr, unmodified.

Reset
REQ-018 On reset, the block SHALL set the FSM to IDLE and clear the following to 0: data_req, data_wr, data_addr, data_wdata, load_valid, load_we, load_reg, load_data, addr_err, addr_err_st, badvaddr.
REQ-019 Reset SHALL take priority over all inputs, including mid-REQ or mid-WAIT; the in-flight access SHALL be abandoned, with data_req = 0 in the cycle after reset is sampled.
REQ-020 stall SHALL be 0 while reset is high.

Verification
REQ-021 Zero-wait load:
- Stimulus: valid_in = 1, mem_to_regfile = 1, addr = 0x8000_0010, dest_reg = 5; data_addr_ok = data_data_ok = 1 with rdata = 0xDEAD_BEEF at T+1.
- Required response: data_req = 1 and data_wr = 0 at T+1; load_valid = 1, load_we = 1, load_reg = 5, load_data = 0xDEAD_BEEF at T+2; stall high T..T+1.
REQ-022 Wait-state store:
- Stimulus: write_mem = 1, addr = 0x1000, wdata = 0x1234_5678; addr_ok delayed 2 cycles; data_ok 3 cycles after addr_ok.
- Required response: data_req held with stable addr/wdata until addr_ok; data_req = 0 in WAIT; load_valid = 1, load_we = 0 one cycle after data_ok.
REQ-023 Misaligned load:
- Stimulus: mem_to_regfile = 1, addr = 0x0000_0002.
- Required response: no data_req; addr_err = 1, addr_err_st = 0, badvaddr = 0x2 for exactly one cycle; stall never asserted.
REQ-024 Load to $0:
- Stimulus: dest_reg = 0, load completes.
- Required response: load_valid = 1, load_we = 0.
REQ-025 Reset mid-WAIT:
- Stimulus: assert reset in WAIT, then data_data_ok arrives after reset.
- Required response: all outputs 0, FSM in IDLE, late data_ok ignored.
REQ-026 Back-to-back:
- Stimulus: a second valid load is presented in the cycle after DONE.
- Required response: accepted immediately; data_req asserted in the following cycle.
